// File: rtl/inst_mem_loader_if.sv
// Byte-stream load port and instruction-fetch port of the instruction-memory loader.
// The slave modport is the loader; the master modport is the stream source / CPU side.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
);
    logic              load_start;
    logic [7:0]        load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] PCout;
    logic [WORD_W-1:0] FetchedInst;
    logic              cpu_reset;
    logic              busy;
    logic              load_done;
    logic [7:0]        word_count;

    modport slave (
        input  load_start, load_len, byte_in, byte_valid, PCout,
        output byte_ready, FetchedInst, cpu_reset, busy, load_done, word_count
    );

    modport master (
        output load_start, load_len, byte_in, byte_valid, PCout,
        input  byte_ready, FetchedInst, cpu_reset, busy, load_done, word_count
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a hi-then-lo byte stream into 16-bit words, writes them into a 2^ADDR_W x WORD_W
// instruction memory, and holds the CPU in reset until the load has completed.
module inst_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    inst_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_word_count;
    logic [8:0]        r_len;
    logic              r_cpu_reset;
    logic [WORD_W-1:0] r_mem [0:(2**ADDR_W)-1];

    logic              w_start;
    logic              w_take_hi;
    logic              w_take_lo;
    logic              w_ready;
    logic              w_last;

    // 9-bit compare so a length of 256 (load_len=0) terminates after the 256th word
    assign w_last = (({1'b0, r_word_count} + 9'd1) == r_len);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_take_hi = 1'b0;
        w_take_lo = 1'b0;
        w_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_start) begin
                    w_start = 1'b1;
                    w_next  = GET_HI;
                end
            end
            GET_HI: begin
                w_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_take_hi = 1'b1;
                    w_next    = GET_LO;
                end
            end
            GET_LO: begin
                w_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_take_lo = 1'b1;
                    w_next    = w_last ? DONE : GET_HI;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi         <= '0;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_len        <= '0;
            r_cpu_reset  <= 1'b1;
        end else begin
            if (w_start) begin
                r_wr_addr    <= '0;
                r_word_count <= '0;
                r_len        <= (bus.load_len == 8'd0) ? 9'd256 : {1'b0, bus.load_len};
                r_cpu_reset  <= 1'b1;
            end
            if (w_take_hi) r_hi <= bus.byte_in;
            if (w_take_lo) begin
                r_wr_addr    <= r_wr_addr + 1'b1;
                r_word_count <= r_word_count + 8'd1;
            end
            if (r_state == DONE) r_cpu_reset <= 1'b0;
        end
    end

    // Memory has no reset: contents survive both reset and subsequent loads
    always_ff @(posedge clock) begin
        if (w_take_lo) r_mem[r_wr_addr] <= {r_hi, bus.byte_in};
    end

    assign bus.FetchedInst = r_mem[bus.PCout];
    assign bus.byte_ready  = w_ready;
    assign bus.busy        = (r_state != IDLE);
    assign bus.load_done   = (r_state == DONE);
    assign bus.cpu_reset   = r_cpu_reset;
    assign bus.word_count  = r_word_count;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: reset state, load timing, stalls, 256-word wrap,
// mid-load reset and ignored restart pulses.
module tb_inst_mem_loader;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] bytes [512];
    int   dc, de, ee, acc;
    logic crd;

    inst_mem_loader_if #(.ADDR_W(8), .WORD_W(16)) bus ();

    inst_mem_loader #(.ADDR_W(8), .WORD_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic read_mem(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        bus.PCout = addr;
        #1;
        check(tag, {16'h0, bus.FetchedInst}, {16'h0, exp});
    endtask

    // e = number of rising edges since the edge that sampled load_start
    task automatic do_load(input logic [7:0] len, input int nbytes, input bit toggle,
                           input int restart_e, output int done_cnt, output int done_e,
                           output int end_e, output int accepted, output logic rst_at_done);
        int   e;
        bit   fin;
        logic xfer;
        done_cnt = 0; done_e = -1; end_e = -1; accepted = 0; rst_at_done = 1'b0; fin = 1'b0;
        @(negedge clock);
        bus.load_start = 1'b1;
        bus.load_len   = len;
        @(negedge clock);
        bus.load_start = 1'b0;
        e = 0;
        while (!fin && e < 3000) begin
            if (bus.load_done) begin
                done_cnt++;
                done_e      = e;
                rst_at_done = bus.cpu_reset;
            end
            if (e > 0 && !bus.busy) begin
                fin   = 1'b1;
                end_e = e;
            end else begin
                bus.byte_valid = (accepted < nbytes) && (!toggle || (e % 2 == 0));
                bus.byte_in    = (accepted < 512) ? bytes[accepted] : 8'h00;
                bus.load_start = (e == restart_e);
                bus.load_len   = (e == restart_e) ? 8'd1 : len;
                xfer = bus.byte_valid && bus.byte_ready;
                @(posedge clock);
                if (xfer) accepted++;
                @(negedge clock);
                e++;
            end
        end
        bus.byte_valid = 1'b0;
        bus.load_start = 1'b0;
        check("load_timeout", {31'h0, fin}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.load_start = 1'b0; bus.load_len = 8'd0; bus.byte_in = 8'd0;
        bus.byte_valid = 1'b0; bus.PCout = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_cpu_reset", {31'h0, bus.cpu_reset}, 32'd1);
            check("idle_busy",      {31'h0, bus.busy},      32'd0);
            check("idle_ready",     {31'h0, bus.byte_ready}, 32'd0);
            check("idle_done",      {31'h0, bus.load_done}, 32'd0);
        end
        check("idle_wcount", {24'h0, bus.word_count}, 32'd0);

        // 3-word continuous load
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
        bytes[3] = 8'h78; bytes[4] = 8'h9A; bytes[5] = 8'hBC;
        do_load(8'd3, 6, 1'b0, -1, dc, de, ee, acc, crd);
        check("c3_done_cnt", dc, 32'd1);
        check("c3_done_e",   de, 32'd6);
        check("c3_end_e",    ee, 32'd7);
        check("c3_rst_at_done", {31'h0, crd}, 32'd1);
        check("c3_cpu_reset", {31'h0, bus.cpu_reset}, 32'd0);
        check("c3_accepted", acc, 32'd6);
        check("c3_wcount", {24'h0, bus.word_count}, 32'd3);
        read_mem("c3_mem0", 8'd0, 16'h1234);
        read_mem("c3_mem1", 8'd1, 16'h5678);
        read_mem("c3_mem2", 8'd2, 16'h9ABC);

        // restart pulse while in GET_LO must be ignored
        for (int i = 0; i < 6; i++) bytes[i] = 8'(i + 1);
        do_load(8'd3, 6, 1'b0, 1, dc, de, ee, acc, crd);
        check("rs_done_cnt", dc, 32'd1);
        check("rs_done_e",   de, 32'd6);
        check("rs_wcount", {24'h0, bus.word_count}, 32'd3);
        read_mem("rs_mem0", 8'd0, 16'h0102);
        read_mem("rs_mem1", 8'd1, 16'h0304);
        read_mem("rs_mem2", 8'd2, 16'h0506);

        // same 3-word load with byte_valid on every other cycle
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
        bytes[3] = 8'h78; bytes[4] = 8'h9A; bytes[5] = 8'hBC;
        do_load(8'd3, 6, 1'b1, -1, dc, de, ee, acc, crd);
        check("tg_done_cnt", dc, 32'd1);
        check("tg_done_e",   de, 32'd11);
        check("tg_accepted", acc, 32'd6);
        check("tg_wcount", {24'h0, bus.word_count}, 32'd3);
        read_mem("tg_mem0", 8'd0, 16'h1234);
        read_mem("tg_mem1", 8'd1, 16'h5678);
        read_mem("tg_mem2", 8'd2, 16'h9ABC);

        // load_len=0 -> 256 words {i, ~i}
        for (int i = 0; i < 256; i++) begin
            bytes[2*i]   = 8'(i);
            bytes[2*i+1] = ~8'(i);
        end
        do_load(8'd0, 512, 1'b0, -1, dc, de, ee, acc, crd);
        check("full_done_cnt", dc, 32'd1);
        check("full_done_e",   de, 32'd512);
        check("full_accepted", acc, 32'd512);
        check("full_wcount", {24'h0, bus.word_count}, 32'd0);
        check("full_cpu_reset", {31'h0, bus.cpu_reset}, 32'd0);
        read_mem("full_mem255", 8'd255, 16'hFF00);
        read_mem("full_mem0",   8'd0,   16'h00FF);
        read_mem("full_mem128", 8'd128, 16'h807F);

        // reset after 3 bytes of a 4-word load
        @(negedge clock);
        bus.load_start = 1'b1; bus.load_len = 8'd4;
        @(negedge clock);
        bus.load_start = 1'b0; bus.byte_valid = 1'b1; bus.byte_in = 8'hAA;
        @(negedge clock);
        bus.byte_in = 8'hBB;
        @(negedge clock);
        bus.byte_in = 8'hCC;
        @(negedge clock);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mr_busy",      {31'h0, bus.busy},       32'd0);
        check("mr_ready",     {31'h0, bus.byte_ready}, 32'd0);
        check("mr_cpu_reset", {31'h0, bus.cpu_reset},  32'd1);
        read_mem("mr_mem0", 8'd0, 16'hAABB);
        read_mem("mr_mem1", 8'd1, 16'h01FE);
        @(negedge clock);
        reset = 1'b0;

        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_load(8'd2, 4, 1'b0, -1, dc, de, ee, acc, crd);
        check("fr_done_cnt", dc, 32'd1);
        check("fr_done_e",   de, 32'd4);
        check("fr_wcount", {24'h0, bus.word_count}, 32'd2);
        check("fr_cpu_reset", {31'h0, bus.cpu_reset}, 32'd0);
        read_mem("fr_mem0", 8'd0, 16'h1122);
        read_mem("fr_mem1", 8'd1, 16'h3344);
        read_mem("fr_mem2", 8'd2, 16'h02FD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
